// File: rtl/wb_spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Package     : wb_spi_pkg
// Description : Shared definitions for the Wishbone SPI responder:
//               register offsets (word index, wb_adr_i[5:2]), STATUS and
//               CTRL bit positions, and the frame FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_spi_pkg;

  // Register word offsets
  localparam logic [3:0] REG_RX   = 4'h0;
  localparam logic [3:0] REG_TX   = 4'h1;
  localparam logic [3:0] REG_STAT = 4'h2;
  localparam logic [3:0] REG_CTRL = 4'h3;

  // STATUS bit positions
  localparam int ST_RX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_CS_ACTIVE = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_UNDERRUN  = 4;

  // CTRL bit positions
  localparam int CT_EN     = 0;
  localparam int CT_RX_IE  = 1;
  localparam int CT_TX_IE  = 2;
  localparam int CT_ERR_IE = 3;

  // Frame FSM encoding
  typedef enum logic [0:0] {
    FSM_IDLE   = 1'b0,
    FSM_ACTIVE = 1'b1
  } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_spi_slave_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync
// Description : N-stage flop synchronizer for one asynchronous input.
//               Fewer than two stages is never built; the depth is clamped.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               i_d   - asynchronous input
//               o_q   - synchronized output (reset value RST_VAL)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {N{RST_VAL}};
    end else begin
      r_sync <= {r_sync[N-2:0], i_d};
    end
  end

  assign o_q = r_sync[N-1];

endmodule
`default_nettype wire

// File: rtl/wb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_spi_slave
// Description : SPI mode-0 responder, 8-bit MSB-first frames, with a
//               Wishbone register port (RX/TX byte buffers, STATUS, CTRL)
//               and a registered level interrupt.
// Ports       : clk, reset (async, active low)
//               wb_*      - Wishbone slave port, one wait state per access
//               spi_sck/spi_cs_n/spi_mosi - asynchronous SPI inputs
//               spi_miso/spi_miso_oe      - data to master and pad enable
//               irq       - level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module wb_spi_slave
  import wb_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_TX     = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  logic w_sck, w_cs_n, w_mosi;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(reset), .i_d(spi_sck), .o_q(w_sck));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(reset), .i_d(spi_cs_n), .o_q(w_cs_n));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(reset), .i_d(spi_mosi), .o_q(w_mosi));

  // Registers
  frame_state_t r_state, w_state_nxt;
  logic         r_sck_prev, r_cs_prev;
  logic [7:0]   r_tx_shift, r_tx_buf, r_rx_buf;
  logic [6:0]   r_rx_shift;
  logic [2:0]   r_bitcnt;
  logic         r_miso, r_miso_oe, r_irq, r_ack;
  logic         r_rx_full, r_tx_empty, r_overrun, r_underrun;
  logic [3:0]   r_ctrl;
  logic [31:0]  r_dat;

  // Combinational
  logic        w_start, w_stop, w_cs_fall, w_edge_ok, w_rise, w_fall;
  logic        w_load, w_rx_done;
  logic [7:0]  w_load_byte, w_rx_byte;
  logic        w_acc, w_rx_rd, w_tx_wr, w_stat_wr, w_ctrl_wr;
  logic [3:0]  w_reg;
  logic [31:0] w_rd_data;
  logic        w_unused;

  assign w_unused = &{1'b0, wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:8]};

  // Edge detection on the last two synchronized samples
  assign w_cs_fall = r_cs_prev & ~w_cs_n;
  // w_stop covers cs_n high or en low, so an active, non-stopping frame
  // already implies cs_n=0 and en=1.
  assign w_edge_ok = (r_state == FSM_ACTIVE) & ~w_stop;
  assign w_rise    = w_edge_ok & ~r_sck_prev &  w_sck;
  assign w_fall    = w_edge_ok &  r_sck_prev & ~w_sck;

  // A TX load happens at frame start and on the fall after each full byte
  assign w_load      = w_start | (w_fall & (r_bitcnt == 3'd0));
  assign w_load_byte = r_tx_empty ? IDLE_TX : r_tx_buf;
  assign w_rx_done   = w_rise & (r_bitcnt == 3'd7);
  assign w_rx_byte   = {r_rx_shift, w_mosi};

  // Wishbone decode: only the first cycle of a strobe is an access
  assign w_acc     = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_reg     = wb_adr_i[5:2];
  assign w_rx_rd   = w_acc & ~wb_we_i & (w_reg == REG_RX);
  assign w_tx_wr   = w_acc &  wb_we_i & (w_reg == REG_TX);
  assign w_stat_wr = w_acc &  wb_we_i & (w_reg == REG_STAT);
  assign w_ctrl_wr = w_acc &  wb_we_i & (w_reg == REG_CTRL);

  always_comb begin
    w_rd_data = 32'd0;
    case (w_reg)
      REG_RX:   w_rd_data = {24'd0, r_rx_buf};
      REG_STAT: w_rd_data = {27'd0, r_underrun, r_overrun, ~w_cs_n, r_tx_empty, r_rx_full};
      REG_CTRL: w_rd_data = {28'd0, r_ctrl};
      default:  w_rd_data = 32'd0;
    endcase
  end

  // Frame FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FSM_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stop      = 1'b0;
    case (r_state)
      FSM_IDLE: begin
        if (w_cs_fall && r_ctrl[CT_EN]) begin
          w_state_nxt = FSM_ACTIVE;
          w_start     = 1'b1;
        end
      end
      FSM_ACTIVE: begin
        if (w_cs_n || !r_ctrl[CT_EN]) begin
          w_state_nxt = FSM_IDLE;
          w_stop      = 1'b1;
        end
      end
      default: w_state_nxt = FSM_IDLE;
    endcase
  end

  // Shift path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sck_prev <= 1'b0;
      r_cs_prev  <= 1'b1;
      r_tx_shift <= IDLE_TX;
      r_rx_shift <= 7'd0;
      r_bitcnt   <= 3'd0;
      r_miso     <= 1'b1;
      r_miso_oe  <= 1'b0;
    end else begin
      r_sck_prev <= w_sck;
      r_cs_prev  <= w_cs_n;
      if (w_stop) begin
        r_miso_oe <= 1'b0;
        r_bitcnt  <= 3'd0;
        r_miso    <= 1'b1;
      end else begin
        if (w_start) begin
          r_miso_oe <= 1'b1;
          r_bitcnt  <= 3'd0;
        end
        // MISO is registered from the next shift value so the first bit
        // appears in the same cycle the shifter loads.
        if (w_load) begin
          r_tx_shift <= w_load_byte;
          r_miso     <= w_load_byte[7];
        end else if (w_fall) begin
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          r_miso     <= r_tx_shift[6];
        end
        if (w_rise) begin
          r_rx_shift <= w_rx_byte[6:0];
          r_bitcnt   <= r_bitcnt + 3'd1;
        end
      end
    end
  end

  // Buffers, flags, control, interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_buf   <= 8'd0;
      r_rx_full  <= 1'b0;
      r_tx_buf   <= IDLE_TX;
      r_tx_empty <= 1'b1;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_ctrl     <= 4'd0;
      r_irq      <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ctrl <= wb_dat_i[3:0];
      // W1C first so a same-cycle error event below takes priority
      if (w_stat_wr && wb_dat_i[ST_OVERRUN])  r_overrun  <= 1'b0;
      if (w_stat_wr && wb_dat_i[ST_UNDERRUN]) r_underrun <= 1'b0;
      if (w_rx_rd) r_rx_full <= 1'b0;
      if (w_rx_done) begin
        if (r_rx_full && !w_rx_rd) begin
          r_overrun <= 1'b1;
        end else begin
          r_rx_buf  <= w_rx_byte;
          r_rx_full <= 1'b1;
        end
      end
      if (w_load) begin
        if (r_tx_empty) r_underrun <= 1'b1;
        r_tx_empty <= 1'b1;
      end
      // A same-cycle CPU write lands after the load consumed the old byte
      if (w_tx_wr) begin
        r_tx_buf   <= wb_dat_i[7:0];
        r_tx_empty <= 1'b0;
      end
      r_irq <= (r_ctrl[CT_RX_IE] & r_rx_full) | (r_ctrl[CT_TX_IE] & r_tx_empty) |
               (r_ctrl[CT_ERR_IE] & (r_overrun | r_underrun));
    end
  end

  // Wishbone response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= wb_cyc_i & wb_stb_i;
      if (w_acc && !wb_we_i) r_dat <= w_rd_data;
    end
  end

  assign wb_dat_o    = r_dat;
  assign wb_ack_o    = wb_cyc_i & wb_stb_i & r_ack;
  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_miso_oe;
  assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_wb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_spi_slave
// Description : Self-checking bench for wb_spi_slave. A mode-0 SPI master
//               and a Wishbone CPU drive the DUT; a buffer/flag model of the
//               register interface predicts every read, MISO byte and irq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_spi_slave;
  import wb_spi_pkg::*;

  localparam int HALF = 8;   // clk cycles per half SCK period (sck = clk/16)

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
  logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, irq;

  always #5 clk = ~clk;

  wb_spi_slave #(.SYNC_STAGES(2), .IDLE_TX(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq(irq));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_rx, m_tx;
  bit         m_rx_full, m_tx_empty, m_ovr, m_udr;
  logic [3:0] m_ctrl;
  logic [7:0] m_exp[$];   // bytes the master should receive, in order

  task automatic m_reset();
    m_rx = 8'h00; m_tx = 8'hFF; m_rx_full = 0; m_tx_empty = 1;
    m_ovr = 0; m_udr = 0; m_ctrl = 4'h0; m_exp.delete();
  endtask

  task automatic m_load();
    if (m_tx_empty) begin
      m_udr = 1;
      m_exp.push_back(8'hFF);
    end else begin
      m_exp.push_back(m_tx);
    end
    m_tx_empty = 1;
  endtask

  task automatic m_rxbyte(input logic [7:0] b);
    if (m_rx_full) m_ovr = 1;
    else begin m_rx = b; m_rx_full = 1; end
  endtask

  function automatic logic [31:0] m_status();
    return {27'd0, m_udr, m_ovr, ~spi_cs_n, m_tx_empty, m_rx_full};
  endfunction

  function automatic logic m_irq();
    return (m_ctrl[1] & m_rx_full) | (m_ctrl[2] & m_tx_empty) | (m_ctrl[3] & (m_ovr | m_udr));
  endfunction

  // ---------------- bus / pin drivers ----------------
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wb_xfer(input logic [3:0] r, input bit we, input logic [31:0] wd,
                         output logic [31:0] rd);
    bit got = 0;
    @(posedge clk); #1;
    wb_adr_i = {26'd0, r, 2'b00}; wb_dat_i = wd; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk); #1;
      if (wb_ack_o) got = 1;
    end
    if (!got) chk("wb_ack_timeout", 32'd0, 32'd1);
    rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic cpu_wr(input logic [3:0] r, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(r, 1'b1, d, dummy);
    case (r)
      REG_TX:   begin m_tx = d[7:0]; m_tx_empty = 0; end
      REG_STAT: begin if (d[3]) m_ovr = 0; if (d[4]) m_udr = 0; end
      REG_CTRL: m_ctrl = d[3:0];
      default: ;
    endcase
  endtask

  task automatic cpu_rd(input logic [3:0] r, input string tag);
    logic [31:0] rd, exp;
    case (r)
      REG_RX:   exp = {24'd0, m_rx};
      REG_STAT: exp = m_status();
      REG_CTRL: exp = {28'd0, m_ctrl};
      default:  exp = 32'd0;
    endcase
    wb_xfer(r, 1'b0, 32'd0, rd);
    chk(tag, rd, exp);
    if (r == REG_RX) m_rx_full = 0;
  endtask

  task automatic chk_irq(input string tag);
    clks(2); #1;
    chk(tag, {31'd0, irq}, {31'd0, m_irq()});
  endtask

  task automatic spi_begin();
    spi_cs_n = 1'b0;
    if (m_ctrl[0]) m_load();
    clks(HALF);
  endtask

  // Shifts nbits MSB-first. With last=1 SCK stays high after the final
  // rise; spi_end raises cs_n before dropping SCK so no trailing fall is seen.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit last);
    logic [7:0] rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      clks(HALF);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      clks(HALF);
      if (!(last && i == 8 - nbits)) spi_sck = 1'b0;
    end
    if (nbits == 8) begin
      if (m_exp.size() > 0) chk("miso_byte", {24'd0, rx}, {24'd0, m_exp.pop_front()});
      if (m_ctrl[0]) m_rxbyte(tx);
      if (!last && m_ctrl[0]) m_load();
    end else if (m_exp.size() > 0) begin
      void'(m_exp.pop_front());
    end
    clks(6);
  endtask

  task automatic spi_end();
    spi_cs_n = 1'b1;
    clks(4);
    spi_sck = 1'b0;
    clks(HALF);
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b0;
    clks(2);
    @(negedge clk); reset = 1'b1;
    m_reset();
    clks(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_reset();
    // ---- reset state ----
    clks(3); #1;
    chk("rst_miso_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("rst_miso", {31'd0, spi_miso}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_dat_o", wb_dat_o, 32'd0);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    @(negedge clk); reset = 1'b1;
    clks(2);
    cpu_rd(REG_STAT, "rst_status");
    cpu_rd(REG_RX, "rst_rx");
    cpu_rd(REG_CTRL, "rst_ctrl");

    // ---- single byte ----
    cpu_wr(REG_TX, 32'hA5);
    cpu_wr(REG_CTRL, 32'h1);
    spi_begin(); spi_byte(8'h3C, 8, 1); spi_end();
    cpu_rd(REG_STAT, "single_status");
    cpu_rd(REG_RX, "single_rx");

    // ---- two-byte burst, refill after first load ----
    cpu_wr(REG_TX, 32'h11);
    spi_begin();
    cpu_wr(REG_TX, 32'h22);
    spi_byte(8'h01, 8, 0);
    cpu_rd(REG_RX, "burst_rx0");
    spi_byte(8'h02, 8, 1);
    spi_end();
    cpu_rd(REG_RX, "burst_rx1");
    cpu_rd(REG_STAT, "burst_status");

    // ---- underrun and overrun ----
    apply_reset();
    cpu_wr(REG_CTRL, 32'h1);
    spi_begin();
    spi_byte(8'h10, 8, 0); spi_byte(8'h20, 8, 0); spi_byte(8'h30, 8, 1);
    spi_end();
    cpu_rd(REG_STAT, "err_status");
    cpu_rd(REG_RX, "err_rx");
    cpu_wr(REG_STAT, 32'h18);
    cpu_rd(REG_STAT, "err_cleared");

    // ---- interrupt ----
    apply_reset();
    cpu_wr(REG_CTRL, 32'h7);
    chk_irq("irq_tx_empty");
    cpu_wr(REG_TX, 32'h55);
    chk_irq("irq_after_tx");
    spi_begin(); spi_byte(8'h9A, 8, 1); spi_end();
    chk_irq("irq_rx_full");
    cpu_rd(REG_RX, "irq_rx");
    cpu_wr(REG_TX, 32'h56);
    chk_irq("irq_cleared");

    // ---- abort after 5 edges, then a clean frame ----
    cpu_wr(REG_STAT, 32'h18);
    spi_begin(); spi_byte(8'hE1, 3, 1); spi_end();
    cpu_rd(REG_STAT, "abort_status");
    cpu_wr(REG_TX, 32'h77);
    spi_begin(); spi_byte(8'h5A, 8, 1); spi_end();
    cpu_rd(REG_STAT, "abort_next_status");
    cpu_rd(REG_RX, "abort_next_rx");

    // ---- asynchronous reset mid-frame ----
    cpu_wr(REG_TX, 32'h99);
    spi_begin();
    spi_byte(8'hC3, 4, 0);
    #1 chk("midrst_oe_before", {31'd0, spi_miso_oe}, 32'd1);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("midrst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("midrst_miso", {31'd0, spi_miso}, 32'd1);
    @(negedge clk); reset = 1'b1;
    m_reset();
    spi_byte(8'hC3, 4, 1);
    spi_end();
    cpu_rd(REG_STAT, "midrst_status");
    cpu_rd(REG_RX, "midrst_rx");
    cpu_wr(REG_CTRL, 32'h1);
    cpu_wr(REG_TX, 32'h81);
    spi_begin(); spi_byte(8'hE7, 8, 1); spi_end();
    cpu_rd(REG_STAT, "midrst_next_status");
    cpu_rd(REG_RX, "midrst_next_rx");

    // ---- randomized frames ----
    for (int it = 0; it < 8; it++) begin
      int nb;
      cpu_wr(REG_CTRL, {28'd0, 3'($urandom_range(0, 7)), 1'b1});
      if ($urandom_range(0, 1) == 1) cpu_wr(REG_TX, 32'($urandom_range(0, 255)));
      nb = $urandom_range(1, 3);
      spi_begin();
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 1) == 1) cpu_wr(REG_TX, 32'($urandom_range(0, 255)));
        spi_byte(8'($urandom_range(0, 255)), 8, b == nb - 1);
        if (b < nb - 1 && $urandom_range(0, 1) == 1) cpu_rd(REG_RX, "rnd_rx_mid");
      end
      spi_end();
      chk_irq("rnd_irq");
      cpu_rd(REG_STAT, "rnd_status");
      if ($urandom_range(0, 1) == 1) cpu_rd(REG_RX, "rnd_rx");
      cpu_wr(REG_STAT, {27'd0, 2'($urandom_range(0, 3)), 3'd0});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
